// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake, DAZ/FTZ and flags.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated toward zero.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4,
  localparam int W    = 1 + EXP_W + MAN_W,
  localparam int BIAS = (1 << (EXP_W - 1)) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);

  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {K_NORM, K_NAN, K_INF, K_ZERO} kind_t;

  // ---------------- handshake ----------------
  logic s1_valid_reg, s2_valid_reg, out_valid_reg;
  logic adv1, adv2, adv3;

  assign adv3     = !out_valid_reg || out_ready;
  assign adv2     = !s2_valid_reg || adv3;
  assign adv1     = !s1_valid_reg || adv2;
  assign in_ready = adv1;

  // ---------------- S1: unpack / classify ----------------
  logic [W-1:0]     op     [2];
  logic [EXP_W-1:0] op_exp [2];
  logic [1:0]       is_nan, is_inf, is_zero;

  assign op[0] = in_a;
  assign op[1] = in_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cls
      assign op_exp[gi]  = op[gi][W-2 -: EXP_W];
      assign is_nan[gi]  = (&op_exp[gi]) & (|op[gi][MAN_W-1:0]);
      assign is_inf[gi]  = (&op_exp[gi]) & ~(|op[gi][MAN_W-1:0]);
      // Denormals are folded into zero here (DAZ).
      assign is_zero[gi] = ~(|op_exp[gi]);
    end
  endgenerate

  kind_t             s1_kind_next;
  logic [EW-1:0]     s1_e_next;

  always_comb begin
    s1_kind_next = K_NORM;
    if (|is_nan || (is_inf[0] && is_zero[1]) || (is_inf[1] && is_zero[0]))
      s1_kind_next = K_NAN;
    else if (|is_inf)
      s1_kind_next = K_INF;
    else if (|is_zero)
      s1_kind_next = K_ZERO;
  end

  assign s1_e_next = {2'b00, op_exp[0]} + {2'b00, op_exp[1]} - EW'(BIAS);

  kind_t             s1_kind_reg;
  logic              s1_sign_reg;
  logic [EW-1:0]     s1_e_reg;
  logic [MAN_W-1:0]  s1_ma_reg, s1_mb_reg;
  logic [TAG_W-1:0]  s1_tag_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_kind_reg  <= K_NORM;
      s1_sign_reg  <= 1'b0;
      s1_e_reg     <= '0;
      s1_ma_reg    <= '0;
      s1_mb_reg    <= '0;
      s1_tag_reg   <= '0;
    end else if (adv1) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_kind_reg <= s1_kind_next;
        s1_sign_reg <= in_a[W-1] ^ in_b[W-1];
        s1_e_reg    <= s1_e_next;
        s1_ma_reg   <= in_a[MAN_W-1:0];
        s1_mb_reg   <= in_b[MAN_W-1:0];
        s1_tag_reg  <= in_tag;
      end
    end
  end

  // ---------------- S2: significand product ----------------
  kind_t             s2_kind_reg;
  logic              s2_sign_reg;
  logic [EW-1:0]     s2_e_reg;
  logic [PW-1:0]     s2_prod_reg;
  logic [TAG_W-1:0]  s2_tag_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_reg <= 1'b0;
      s2_kind_reg  <= K_NORM;
      s2_sign_reg  <= 1'b0;
      s2_e_reg     <= '0;
      s2_prod_reg  <= '0;
      s2_tag_reg   <= '0;
    end else if (adv2) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_kind_reg <= s1_kind_reg;
        s2_sign_reg <= s1_sign_reg;
        s2_e_reg    <= s1_e_reg;
        s2_prod_reg <= {1'b1, s1_ma_reg} * {1'b1, s1_mb_reg};
        s2_tag_reg  <= s1_tag_reg;
      end
    end
  end

  // ---------------- S3: normalise / round / pack ----------------
  logic                 prod_msb;
  logic [PW-2:0]        frac;
  logic [MAN_W-1:0]     mant, mant_f;
  logic                 guard_bit, round_bit, sticky_bit, carry;
  logic signed [EW-1:0] e_n, e_f;
  logic [W-1:0]         res_next;
  logic [3:0]           flags_next;

  // frac has the leading one removed, so a right shift by one is just a different slice.
  assign prod_msb   = s2_prod_reg[PW-1];
  assign frac       = prod_msb ? s2_prod_reg[PW-2:0] : {s2_prod_reg[PW-3:0], 1'b0};
  assign mant       = frac[PW-2 -: MAN_W];
  assign guard_bit  = frac[MAN_W];
  assign round_bit  = frac[MAN_W-1];
  assign sticky_bit = |frac[MAN_W-2:0];

`ifdef FP_MUL_RNE_EN
  logic             round_up;
  logic [MAN_W:0]   mant_sum;
  assign round_up = guard_bit & (round_bit | sticky_bit | mant[0]);
  assign mant_sum = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
  assign mant_f   = mant_sum[MAN_W-1:0];
  assign carry    = mant_sum[MAN_W];
`else
  assign mant_f = mant;
  assign carry  = 1'b0;
`endif

  assign e_n = s2_e_reg + {{(EW-1){1'b0}}, prod_msb};
  assign e_f = e_n + {{(EW-1){1'b0}}, carry};

  always_comb begin
    res_next   = '0;
    flags_next = 4'b0000;
    case (s2_kind_reg)
      K_NAN: begin
        res_next   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flags_next = 4'b1000;
      end
      K_INF:  res_next = {s2_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      K_ZERO: res_next = {s2_sign_reg, {(W-1){1'b0}}};
      default: begin
        if (e_f >= E_MAX) begin
          res_next   = {s2_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_next = 4'b0101;
        end else if (e_f[EW-1] || (e_f == '0)) begin
          res_next   = {s2_sign_reg, {(W-1){1'b0}}};
          flags_next = 4'b0011;
        end else begin
          res_next   = {s2_sign_reg, e_f[EXP_W-1:0], mant_f};
          flags_next = {3'b000, guard_bit | round_bit | sticky_bit};
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_res       <= '0;
      out_tag       <= '0;
      out_flags     <= '0;
    end else if (adv3) begin
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        out_res   <= res_next;
        out_tag   <= s2_tag_reg;
        out_flags <= flags_next;
      end
    end
  end

  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: directed FP32 vectors, latency, backpressure and mid-stream reset.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_res;
  logic [3:0]  in_tag, out_tag, out_flags;

  fp_mul_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_tag(out_tag), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] res; logic [3:0] tag; logic [3:0] flags; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] res; logic [3:0] flags; } vec_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  vec_t vecs [11];
  initial begin
    vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
    vecs[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000};
    vecs[2]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101};
    vecs[3]  = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011};
    vecs[4]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000};
    vecs[5]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
    vecs[6]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000};
    vecs[7]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
`ifdef FP_MUL_RNE_EN
    vecs[8]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001};
`else
    vecs[8]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00001, 4'b0001};
`endif
    vecs[9]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
    vecs[10] = '{32'h80800000, 32'h00800000, 32'h80000000, 4'b0011};
  end

  // Output monitor: pops the scoreboard on each transfer and checks hold stability.
  logic        hold_valid = 1'b0;
  logic [31:0] hold_res;
  logic [3:0]  hold_tag, hold_flags;

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (hold_valid) begin
        check("hold_res", out_res, hold_res);
        check("hold_tag", out_tag, hold_tag);
        check("hold_flags", out_flags, hold_flags);
      end
      if (out_ready) begin
        hold_valid = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("out tag=%0d res=%08h flags=%04b (exp %08h %04b)", out_tag, out_res, out_flags, e.res, e.flags);
          check("res", out_res, e.res);
          check("tag", out_tag, e.tag);
          check("flags", out_flags, e.flags);
        end
      end else begin
        hold_valid = 1'b1;
        hold_res   = out_res;
        hold_tag   = out_tag;
        hold_flags = out_flags;
      end
    end else begin
      hold_valid = 1'b0;
    end
  end

  task automatic send(input int vi, input logic [3:0] tag);
    bit got = 0;
    in_a = vecs[vi].a;
    in_b = vecs[vi].b;
    in_tag = tag;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{vecs[vi].res, tag, vecs[vi].flags});
        got = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_res", out_res, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Latency of a single operation
    out_ready = 1'b1;
    send(0, 4'd7);
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("latency", cnt, 3);
    drain();

    // All directed vectors back to back
    for (int i = 0; i < 11; i++) send(i, 4'(i));
    drain();

    // Backpressure: three accepts fill the pipe, then in_ready must drop
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(i, 4'(i));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("in_ready_full", in_ready, 0);
    end
    @(posedge clk);
    #1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          @(posedge clk);
          #1;
          out_ready = ~out_ready;
        end
      end
      begin
        for (int i = 3; i < 6; i++) send(i, 4'(i));
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset mid-stream: in-flight results must vanish
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(i + 7, 4'(i + 10));
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_res", out_res, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send(1, 4'd9);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
